uart_fifo_controller: RTL
=========================

// Module: uart_fifo_controller
// PURPOSE
//  Buffered, parametrised controller for the board's CPLD UART. Decouples the CPU bus from
//  UART timing via TX/RX FIFOs, generates uart_wrn/uart_rdn strobes of configurable width,
//  and arbitrates the data lines shared with BaseRam through a bus_req/bus_gnt handshake.
// PARAMETERS
//  TX_DEPTH       16  TX FIFO entries; power of two, >=2
//  RX_DEPTH       16  RX FIFO entries; power of two, >=2
//  STROBE_CYCLES  2   low width of uart_wrn/uart_rdn in clk cycles; >=1
// PORTS
//  clk             in   1   clock
//  rst             in   1   asynchronous reset, active-high
//  tx_data         in   8   byte to send
//  tx_valid        in   1   tx_data valid; pushed when tx_valid&&tx_ready
//  tx_ready        out  1   TX FIFO not full
//  rx_data         out  8   head of RX FIFO (show-ahead)
//  rx_valid        out  1   RX FIFO not empty
//  rx_ready        in   1   pop RX head when rx_valid&&rx_ready
//  tx_count        out  $clog2(TX_DEPTH+1)  TX FIFO occupancy
//  rx_count        out  $clog2(RX_DEPTH+1)  RX FIFO occupancy
//  bus_req         out  1   request for shared BaseRam/UART data lines
//  bus_gnt         in   1   shared lines granted
//  uart_rdn        out  1   UART read strobe, active-low
//  uart_wrn        out  1   UART write strobe, active-low
//  uart_dataready  in   1   UART has a received byte
//  uart_tbre       in   1   transmit buffer empty
//  uart_tsre       in   1   transmit shift register empty
//  uart_data_i     in   8   shared data lines, input side
//  uart_data_o     out  8   shared data lines, output value
//  uart_data_oe    out  1   drive enable for uart_data_o (top level builds the tristate)
// BEHAVIOUR
//  Reset (async, immediate): uart_rdn=1, uart_wrn=1, uart_data_oe=0, uart_data_o=0,
//   bus_req=0, both FIFOs empty (tx_ready=1, rx_valid=0, counts 0), state IDLE.
//  All UART-side outputs registered. FIFOs: push ignored when full, pop ignored when empty;
//   push+pop same cycle on a non-full/non-empty FIFO leaves count unchanged. tx_ready is
//   from current count (no bypass when full). Pointers wrap modulo depth.
//  bus_req=1 whenever state!=IDLE, and in IDLE whenever work is pending (RX or TX condition).
//  FSM (from IDLE, only when bus_gnt=1; RX has priority):
//   IDLE: uart_dataready && rx_count<RX_DEPTH -> RD_STROBE (rdn<=0);
//         else tx_count>0 -> WR_SETUP (data_o<=TX head, oe<=1, pop TX).
//   RD_STROBE: rdn low STROBE_CYCLES cycles; on last cycle capture uart_data_i into RX FIFO,
//         rdn<=1 -> RD_RECOVER.  RD_RECOVER: 1 cycle -> IDLE.
//   WR_SETUP: 1 cycle data setup -> WR_STROBE (wrn<=0).
//   WR_STROBE: wrn low STROBE_CYCLES cycles, then wrn<=1 -> WR_HOLD.
//   WR_HOLD: 1 cycle data hold, oe<=0 -> WR_WAIT_TBRE.
//   WR_WAIT_TBRE: wait uart_tbre=1 -> WR_WAIT_TSRE. WR_WAIT_TSRE: wait uart_tsre=1 -> IDLE.
//  oe is never 1 while rdn=0. rdn and wrn are never both low.
//  RX FIFO full: dataready is left pending (no read, no data loss); read resumes once popped.
//  bus_gnt dropped mid-transaction is ignored; the transaction completes.
//  Latency: TX byte pushed at cycle 0 (idle, gnt=1) -> wrn falls at edge 3 (via WR_SETUP).
//  Reset mid-transaction aborts at once: strobes deassert, oe drops, FIFO contents lost.
// TESTING
//  1 Push 0x41, gnt=1, tbre/tsre=1 after 4 cycles -> oe=1 for 1 setup cycle, wrn low exactly
//    STROBE_CYCLES with uart_data_o=0x41, 1 hold cycle, return to IDLE, tx_count 0.
//  2 dataready=1, uart_data_i=0x5A -> rdn low STROBE_CYCLES, rx_valid=1, rx_data=0x5A, oe=0.
//  3 Push TX_DEPTH bytes 0..15 with gnt=0 -> tx_ready=0, 17th push dropped; gnt=1 -> bytes
//    emitted in order 0..15, tx_count decrements once per byte.
//  4 dataready and TX pending together -> read completes before write; RX full with
//    dataready=1 -> rdn stays 1 until one rx pop, then one read.
//  5 Assert rst during WR_STROBE -> wrn=1, oe=0, bus_req=0 same cycle; counts 0.
//  6 Simultaneous rx pop and RX capture at rx_count=3 -> count stays 3, order preserved.

Source files
------------

// File: rtl/uart_fifo_controller_if.sv
// Host/UART-side signal bundle for uart_fifo_controller.
// The controller uses the slave modport; the host or bench uses the master modport.
interface uart_fifo_controller_if #(
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16
);
    logic [7:0]                     tx_data;
    logic                           tx_valid;
    logic                           tx_ready;
    logic [7:0]                     rx_data;
    logic                           rx_valid;
    logic                           rx_ready;
    logic [$clog2(TX_DEPTH+1)-1:0]  tx_count;
    logic [$clog2(RX_DEPTH+1)-1:0]  rx_count;
    logic                           bus_req;
    logic                           bus_gnt;
    logic                           uart_rdn;
    logic                           uart_wrn;
    logic                           uart_dataready;
    logic                           uart_tbre;
    logic                           uart_tsre;
    logic [7:0]                     uart_data_i;
    logic [7:0]                     uart_data_o;
    logic                           uart_data_oe;

    modport master (
        output tx_data, tx_valid, rx_ready, bus_gnt, uart_dataready, uart_tbre, uart_tsre,
               uart_data_i,
        input  tx_ready, rx_data, rx_valid, tx_count, rx_count, bus_req, uart_rdn, uart_wrn,
               uart_data_o, uart_data_oe
    );

    modport slave (
        input  tx_data, tx_valid, rx_ready, bus_gnt, uart_dataready, uart_tbre, uart_tsre,
               uart_data_i,
        output tx_ready, rx_data, rx_valid, tx_count, rx_count, bus_req, uart_rdn, uart_wrn,
               uart_data_o, uart_data_oe
    );
endinterface

// File: rtl/uart_fifo_controller.sv
// Buffered CPLD UART controller: TX/RX FIFOs, timed rdn/wrn strobes and a
// bus_req/bus_gnt handshake for the data lines shared with BaseRam.
module uart_fifo_controller #(
    parameter int unsigned TX_DEPTH      = 16,
    parameter int unsigned RX_DEPTH      = 16,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    uart_fifo_controller_if.slave bus
);
    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam int unsigned TxCw = $clog2(TX_DEPTH + 1);
    localparam int unsigned RxCw = $clog2(RX_DEPTH + 1);
    localparam int unsigned StbW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [TxCw-1:0] TxFull  = TxCw'(TX_DEPTH);
    localparam logic [RxCw-1:0] RxFull  = RxCw'(RX_DEPTH);
    localparam logic [StbW-1:0] StbLast = StbW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdStrobe,
        StRdRecover,
        StWrSetup,
        StWrStrobe,
        StWrHold,
        StWrWaitTbre,
        StWrWaitTsre
    } state_e;

    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TxAw-1:0] tx_wr_q, tx_rd_q;
    logic [TxCw-1:0] tx_cnt_q;
    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RxAw-1:0] rx_wr_q, rx_rd_q;
    logic [RxCw-1:0] rx_cnt_q;

    state_e          state_q;
    logic [StbW-1:0] stb_cnt_q;
    logic            rdn_q, wrn_q, oe_q;
    logic [7:0]      data_o_q;

    logic tx_push, tx_pop, rx_push, rx_pop, rd_start, wr_start;

    // A full RX FIFO leaves dataready pending rather than losing the byte.
    assign rd_start = bus.uart_dataready && (rx_cnt_q != RxFull);
    assign wr_start = !rd_start && (tx_cnt_q != '0);
    assign tx_push  = bus.tx_valid && (tx_cnt_q != TxFull);
    assign tx_pop   = (state_q == StIdle) && bus.bus_gnt && wr_start;
    assign rx_push  = (state_q == StRdStrobe) && (stb_cnt_q == StbLast);
    assign rx_pop   = bus.rx_ready && (rx_cnt_q != '0);

    assign bus.tx_ready     = (tx_cnt_q != TxFull);
    assign bus.tx_count     = tx_cnt_q;
    assign bus.rx_valid     = (rx_cnt_q != '0);
    assign bus.rx_data      = rx_mem[rx_rd_q];
    assign bus.rx_count     = rx_cnt_q;
    assign bus.uart_rdn     = rdn_q;
    assign bus.uart_wrn     = wrn_q;
    assign bus.uart_data_oe = oe_q;
    assign bus.uart_data_o  = data_o_q;
    assign bus.bus_req      = !rst && ((state_q != StIdle) || rd_start || (tx_cnt_q != '0));

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= bus.tx_data;
        if (rx_push) rx_mem[rx_wr_q] <= bus.uart_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + TxAw'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + TxAw'(1);
            if (rx_push) rx_wr_q <= rx_wr_q + RxAw'(1);
            if (rx_pop)  rx_rd_q <= rx_rd_q + RxAw'(1);
            tx_cnt_q <= tx_cnt_q + TxCw'(tx_push) - TxCw'(tx_pop);
            rx_cnt_q <= rx_cnt_q + RxCw'(rx_push) - RxCw'(rx_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            stb_cnt_q <= '0;
            rdn_q     <= 1'b1;
            wrn_q     <= 1'b1;
            oe_q      <= 1'b0;
            data_o_q  <= 8'h00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.bus_gnt) begin
                        if (rd_start) begin
                            state_q   <= StRdStrobe;
                            rdn_q     <= 1'b0;
                            stb_cnt_q <= '0;
                        end else if (wr_start) begin
                            state_q  <= StWrSetup;
                            data_o_q <= tx_mem[tx_rd_q];
                            oe_q     <= 1'b1;
                        end
                    end
                end
                StRdStrobe: begin
                    if (stb_cnt_q == StbLast) begin
                        rdn_q   <= 1'b1;
                        state_q <= StRdRecover;
                    end else begin
                        stb_cnt_q <= stb_cnt_q + StbW'(1);
                    end
                end
                StRdRecover: state_q <= StIdle;
                StWrSetup: begin
                    state_q   <= StWrStrobe;
                    wrn_q     <= 1'b0;
                    stb_cnt_q <= '0;
                end
                StWrStrobe: begin
                    if (stb_cnt_q == StbLast) begin
                        wrn_q   <= 1'b1;
                        state_q <= StWrHold;
                    end else begin
                        stb_cnt_q <= stb_cnt_q + StbW'(1);
                    end
                end
                StWrHold: begin
                    oe_q    <= 1'b0;
                    state_q <= StWrWaitTbre;
                end
                StWrWaitTbre: if (bus.uart_tbre) state_q <= StWrWaitTsre;
                StWrWaitTsre: if (bus.uart_tsre) state_q <= StIdle;
                default:      state_q <= StIdle;
            endcase
        end
    end
endmodule
